// File: rtl/priv_1_12_arb_pkg.sv
// Shared types for the CSR port arbiter: CSR op encoding, arbiter FSM states
// and the op-to-strobe decode used to drive the CSR file.
package priv_1_12_arb_pkg;

  localparam int CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    RO    = 2'b00,
    SWAP  = 2'b01,
    SET   = 2'b10,
    CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic {
    ARB  = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic write;
    logic set;
    logic clear;
    logic read_only;
  } csr_strobe_t;

  function automatic csr_strobe_t op_to_strobe(input csr_op_t op);
    csr_strobe_t s;
    s = '0;
    case (op)
      RO:      s.read_only = 1'b1;
      SWAP:    s.write     = 1'b1;
      SET:     s.set       = 1'b1;
      CLEAR:   s.clear     = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/priv_1_12_csr_arbiter.sv
// Shares the CSR read-modify-write port between the pipeline (priority) and a
// debug port with starvation protection and a one-entry debug response buffer.
module priv_1_12_csr_arbiter
  import priv_1_12_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pipe_req,
  input  logic [CSR_ADDR_W-1:0] pipe_addr,
  input  csr_op_t               pipe_op,
  input  logic [DATA_W-1:0]     pipe_wdata,
  output logic                  pipe_gnt,
  output logic                  pipe_stall,
  output logic [DATA_W-1:0]     pipe_rdata,
  output logic                  pipe_invalid,
  input  logic                  dbg_req,
  input  logic [CSR_ADDR_W-1:0] dbg_addr,
  input  csr_op_t               dbg_op,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_rerr,
  input  logic                  dbg_rready,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_write,
  output logic                  csr_set,
  output logic                  csr_clear,
  output logic                  csr_read_only,
  output logic [DATA_W-1:0]     csr_wdata,
  input  logic [DATA_W-1:0]     csr_rdata,
  input  logic                  csr_invalid
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state, state_next;
  logic [3:0]  starve_cnt, starve_next;
  logic        dbg_ok, force_gnt;
  csr_strobe_t strobe;

  // Grants are masked during reset so no strobe reaches the CSR file then.
  assign dbg_ok     = dbg_req & (state == ARB) & ~RST;
  assign force_gnt  = dbg_ok & (starve_cnt == LIMIT);
  assign dbg_gnt    = dbg_ok & (~pipe_req | force_gnt);
  assign pipe_gnt   = pipe_req & ~dbg_gnt & ~RST;
  assign pipe_stall = pipe_req & ~pipe_gnt;

  assign pipe_rdata   = csr_rdata;
  assign pipe_invalid = csr_invalid;
  assign dbg_rvalid   = (state == RESP);

  always_comb begin
    strobe    = '0;
    csr_addr  = '0;
    csr_wdata = '0;
    if (dbg_gnt) begin
      strobe    = op_to_strobe(dbg_op);
      csr_addr  = dbg_addr;
      csr_wdata = dbg_wdata;
    end else if (pipe_gnt) begin
      strobe    = op_to_strobe(pipe_op);
      csr_addr  = pipe_addr;
      csr_wdata = pipe_wdata;
    end
  end

  assign csr_write     = strobe.write;
  assign csr_set       = strobe.set;
  assign csr_clear     = strobe.clear;
  assign csr_read_only = strobe.read_only;

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    case (state)
      ARB:     if (dbg_gnt) state_next = RESP;
      RESP:    if (dbg_rready) state_next = ARB;
      default: state_next = ARB;
    endcase
    if (dbg_gnt || !dbg_req) begin
      starve_next = '0;
    end else if (dbg_ok && pipe_gnt && starve_cnt != LIMIT) begin
      starve_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB;
      starve_cnt <= '0;
      dbg_rdata  <= '0;
      dbg_rerr   <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (dbg_gnt) begin
        dbg_rdata <= csr_rdata;
        dbg_rerr  <= csr_invalid;
      end
    end
  end

endmodule
